spi_regmap_bridge: RTL and testbench
====================================

# spi_regmap_bridge

Parametrised SPI-to-register bridge between the word-level SPI slave core (SCK domain) and the accelerator cores (GCD, Sobel, later channels) in the clk_i domain. It synchronises the core's word-done flag, decodes each received word as a read or a write to an indexed register, and drives write registers with per-register strobes. It returns read data or status in the transmit word of the next SPI transaction, and keeps sticky error flags and a word counter.

## Interface
- STREAM_DATA_WIDTH, 16, SPI word width W
- ADDR_W, 4, address field width; address 2^ADDR_W-1 is reserved for status
- NUM_WR, 4, write registers, 1..2^ADDR_W-1
- NUM_RD, 4, read inputs, 1..2^ADDR_W-1
- SWAP_BYTES, 1, if 1 swap the two bytes of rx and tx words at the core boundary (W=16 only)
- Derived: DATA_W = W-1-ADDR_W (11 by default); CNT_W = DATA_W-2
- clk_i, in, 1, system clock
- nreset_i, in, 1, asynchronous active-low reset
- spi_cs_i, in, 1, chip select, active-low, asynchronous
- spi_rxtx_done_i, in, 1, word-done level from the SPI core, asynchronous
- spi_rx_word_i, in, W, received word; the core holds it stable for at least 6 clk_i cycles after done rises
- spi_tx_word_o, out, W, word shifted out in the next transaction
- wr_data_o, out, NUM_WR*DATA_W, write registers, register k at [k*DATA_W +: DATA_W]
- wr_stb_o, out, NUM_WR, one-cycle pulse when register k is written
- rd_data_i, in, NUM_RD*DATA_W, read sources, same packing
- status_o, out, 2, {err_abort, err_addr} sticky flags

## Operation
- Command word, after optional swap: bit W-1 is the operation (1 = write, 0 = read); bits [W-2 -: ADDR_W] are the address a; bits [DATA_W-1:0] are the data d.
- Write, a<NUM_WR: wr_data_o[a] <= d; wr_stb_o[a] pulses.
- Read, a<NUM_RD: spi_tx_word_o <= {1'b0, a, rd_data_i[a]}, sampled at decode.
- Status address a=2^ADDR_W-1:
  - Read returns data {word_cnt, err_abort, err_addr}.
  - Write with d[0]=1 clears both flags and word_cnt.
- Out-of-range address (write a>=NUM_WR or read a>=NUM_RD, not the status address): err_addr set; no register changes; a read loads tx word 0.
- word_cnt is CNT_W bits, increments on every accepted word and wraps at 2^CNT_W-1 -> 0.
- Abort: spi_cs_i (synchronised) deasserts with no accepted word since it asserted -> err_abort set.
- Set beats clear when both occur in the same cycle.
- spi_tx_word_o holds its value until the next read command or a reset.

## Timing
- spi_rxtx_done_i and ~spi_cs_i each pass through a two-flop synchroniser.
- A rising edge on synchronised done produces word_vld.
  - word_vld is accepted only when `armed` is set.
  - `armed` resets to 0 and sets the first cycle synchronised done is seen low.
  - Result: a done level already high at reset release is ignored.
- Latency from the done rising edge to outputs:
  - Edge 1-2: synchroniser.
  - Edge 3: word_vld and capture of spi_rx_word_i.
  - Edge 4: decode. wr_data_o, wr_stb_o, spi_tx_word_o, status_o and word_cnt update.
- At most one word is processed per done edge. Back-to-back words need at least 4 clk_i cycles between done rising edges.
- Reset values: wr_data_o 0, wr_stb_o 0, spi_tx_word_o 0, status_o 0, word_cnt 0, armed 0, synchronisers 0.
- A reset asserted mid-word discards the word. No strobe is issued for it after release.

## Structure
- Package spi_regmap_pkg holds:
  - the operation enum (OP_READ=0, OP_WRITE=1);
  - function status_addr(ADDR_W);
  - the field-position localparams.
- Sub-module spi_regmap_sync2: two-flop synchroniser with asynchronous active-low reset, instantiated twice.
- The decode and register file stay in the top module.

## Test plan
- Write 0xA003 (W=16, no swap: write, a=4)... → err_addr=1, no strobe. Then write 0x8805 (a=1, d=5) → wr_stb_o=0b0010 for exactly one cycle, 4 edges after done; wr_data_o[1]=5.
- rd_data_i[2]=0x123; send 0x1000 (read a=2) → spi_tx_word_o=0x1123, held through 3 further writes.
- Send 0x7800 (status read) after 3 accepted words with err_addr set → tx data = (3<<2)|1. Then send 0xF801 (status write, d[0]=1) → status_o=0, word_cnt=0.
- Assert then release spi_cs_i with no done pulse → err_abort=1. Same sequence with one word → no flag.
- Hold done high across reset release → no strobe until done falls and rises again.
- Send 2^CNT_W accepted words → word_cnt wraps to 0. With SWAP_BYTES=1, rx 0x0588 decodes as 0x8805.

Source files
------------

// File: rtl/spi_regmap_pkg.sv
// Shared definitions for the SPI register bridge.
// Holds the command operation encoding, the word field offsets (measured from
// the MSB so they hold for any word width), the status flag bit positions and
// the helper that yields the reserved status address.
package spi_regmap_pkg;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Operation bit sits at W-OP_OFS, the address field MSB at W-ADDR_OFS.
  localparam int OP_OFS   = 1;
  localparam int ADDR_OFS = 2;

  // Sticky flag positions inside status_o and the status read data.
  localparam int ERR_ADDR_BIT  = 0;
  localparam int ERR_ABORT_BIT = 1;
  localparam int STATUS_W      = 2;

  // The top address of the field is reserved for status/control.
  function automatic int status_addr(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/spi_regmap_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//   clk_i     destination clock
//   nreset_i  asynchronous active-low reset, clears both flops
//   d         asynchronous input level
//   q         synchronised level, two clk_i edges behind d
module spi_regmap_sync2 (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_regmap_bridge.sv
// SPI word to register-file bridge.
// Each word finished by the SPI core is decoded as a read or write of an
// indexed register. Writes update a packed register file and pulse a per
// register strobe; reads load the transmit word returned in the next SPI
// transaction. The top address is a status register (word count and sticky
// error flags, clearable by writing d[0]=1).
// Ports:
//   clk_i, nreset_i   system clock, asynchronous active-low reset
//   spi_cs_i          chip select (active-low, asynchronous)
//   spi_rxtx_done_i   word-done level from the SPI core (asynchronous)
//   spi_rx_word_i     received word, stable while done is high
//   spi_tx_word_o     word to shift out in the next transaction
//   wr_data_o         write registers, register k at [k*DATA_W +: DATA_W]
//   wr_stb_o          one-cycle write strobe per register
//   rd_data_i         read sources, same packing as wr_data_o
//   status_o          {err_abort, err_addr}
module spi_regmap_bridge
  import spi_regmap_pkg::*;
#(
  parameter int  STREAM_DATA_WIDTH = 16,
  parameter int  ADDR_W            = 4,
  parameter int  NUM_WR            = 4,
  parameter int  NUM_RD            = 4,
  parameter int  SWAP_BYTES        = 1,
  localparam int DATA_W            = STREAM_DATA_WIDTH - 1 - ADDR_W
) (
  input  logic                       clk_i,
  input  logic                       nreset_i,
  input  logic                       spi_cs_i,
  input  logic                       spi_rxtx_done_i,
  input  logic [STREAM_DATA_WIDTH-1:0] spi_rx_word_i,
  output logic [STREAM_DATA_WIDTH-1:0] spi_tx_word_o,
  output logic [NUM_WR*DATA_W-1:0]   wr_data_o,
  output logic [NUM_WR-1:0]          wr_stb_o,
  input  logic [NUM_RD*DATA_W-1:0]   rd_data_i,
  output logic [STATUS_W-1:0]        status_o
);

  localparam int W        = STREAM_DATA_WIDTH;
  localparam int CNT_W    = DATA_W - 2;
  localparam int OP_POS   = W - OP_OFS;
  localparam int ADDR_MSB = W - ADDR_OFS;
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(status_addr(ADDR_W));

  logic          done_s, done_q, cs_s, cs_q;
  logic [1:0]    settle;
  logic          armed, seen;
  logic          vld_p0;
  logic [W-1:0]  rx_word, rx_p0, tx_word;
  logic          err_addr, err_abort;
  logic [CNT_W-1:0] word_cnt;

  spi_regmap_sync2 u_sync_done (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .d        (spi_rxtx_done_i),
    .q        (done_s)
  );

  spi_regmap_sync2 u_sync_cs (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .d        (~spi_cs_i),
    .q        (cs_s)
  );

  if (SWAP_BYTES == 1 && W == 16) begin : g_swap
    assign rx_word       = {spi_rx_word_i[7:0], spi_rx_word_i[W-1:8]};
    assign spi_tx_word_o = {tx_word[7:0], tx_word[W-1:8]};
  end else begin : g_noswap
    assign rx_word       = spi_rx_word_i;
    assign spi_tx_word_o = tx_word;
  end

  // Decode fields of the captured word.
  op_e               op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data, rd_sel, status_data;
  logic              is_stat, wr_ok, rd_ok, addr_err, stat_clr, abort_set;

  assign op          = op_e'(rx_p0[OP_POS]);
  assign addr        = rx_p0[ADDR_MSB -: ADDR_W];
  assign data        = rx_p0[DATA_W-1:0];
  assign is_stat     = (addr == STAT_ADDR);
  assign wr_ok       = (op == OP_WRITE) && !is_stat && (int'(addr) < NUM_WR);
  assign rd_ok       = (op == OP_READ) && !is_stat && (int'(addr) < NUM_RD);
  assign addr_err    = vld_p0 && !is_stat && !wr_ok && !rd_ok;
  assign stat_clr    = vld_p0 && is_stat && (op == OP_WRITE) && data[0];
  assign status_data = {word_cnt, err_abort, err_addr};
  // Chip select released without any accepted word since it was asserted.
  assign abort_set   = cs_q && !cs_s && !seen && !vld_p0;
  assign status_o    = {err_abort, err_addr};

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (addr == ADDR_W'(k)) rd_sel = rd_data_i[k*DATA_W +: DATA_W];
    end
  end

  // Stage p0: edge detect on synchronised done, capture of the rx word.
  // armed only sets once the synchronisers have flushed the reset value and
  // then show done low, so a done level already high at reset release is
  // never mistaken for a fresh rising edge.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      done_q <= 1'b0;
      cs_q   <= 1'b0;
      settle <= 2'b00;
      armed  <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      done_q <= done_s;
      cs_q   <= cs_s;
      settle <= {settle[0], 1'b1};
      armed  <= armed | (settle[1] & ~done_s);
      vld_p0 <= done_s & ~done_q & armed;
    end
  end

  always_ff @(posedge clk_i) begin
    rx_p0 <= rx_word;
  end

  // Stage p1: decode into register file, tx word, flags and counter.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_data_o <= '0;
      wr_stb_o  <= '0;
      tx_word   <= '0;
      err_addr  <= 1'b0;
      err_abort <= 1'b0;
      word_cnt  <= '0;
      seen      <= 1'b0;
    end else begin
      wr_stb_o <= '0;
      if (vld_p0 && wr_ok) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (addr == ADDR_W'(k)) begin
            wr_data_o[k*DATA_W +: DATA_W] <= data;
            wr_stb_o[k]                   <= 1'b1;
          end
        end
      end
      if (vld_p0 && (op == OP_READ)) begin
        if (addr_err) tx_word <= '0;
        else          tx_word <= {1'b0, addr, is_stat ? status_data : rd_sel};
      end
      // Setting a flag wins over a simultaneous clear.
      if (addr_err)      err_addr <= 1'b1;
      else if (stat_clr) err_addr <= 1'b0;
      if (abort_set)     err_abort <= 1'b1;
      else if (stat_clr) err_abort <= 1'b0;
      if (stat_clr)      word_cnt <= '0;
      else if (vld_p0)   word_cnt <= word_cnt + 1'b1;
      if (vld_p0)                 seen <= 1'b1;
      else if (cs_s && !cs_q)     seen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_regmap_bridge.sv
// Bench for spi_regmap_bridge: two instances (no swap / byte swap) fed the
// same logical words, a behavioural register-map model checked every cycle,
// plus literal expectations from hand-worked command words.
module tb_spi_regmap_bridge;

  localparam int W   = 16;
  localparam int AW  = 4;
  localparam int NWR = 4;
  localparam int NRD = 4;
  localparam int DW  = W - 1 - AW;
  localparam int CW  = DW - 2;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic cs = 1'b1;
  logic done = 1'b0;
  logic [W-1:0] rx = '0;
  logic [W-1:0] rx_sw, tx, tx_sw;
  logic [NWR*DW-1:0] wr, wr_sw;
  logic [NWR-1:0] stb, stb_sw;
  logic [NRD*DW-1:0] rd_data = '0;
  logic [1:0] status, status_sw;

  assign rx_sw = {rx[7:0], rx[15:8]};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_regmap_bridge #(.STREAM_DATA_WIDTH(W), .ADDR_W(AW), .NUM_WR(NWR),
                      .NUM_RD(NRD), .SWAP_BYTES(0)) u_dut (
    .clk_i(clk), .nreset_i(nreset), .spi_cs_i(cs), .spi_rxtx_done_i(done),
    .spi_rx_word_i(rx), .spi_tx_word_o(tx), .wr_data_o(wr), .wr_stb_o(stb),
    .rd_data_i(rd_data), .status_o(status));

  spi_regmap_bridge #(.STREAM_DATA_WIDTH(W), .ADDR_W(AW), .NUM_WR(NWR),
                      .NUM_RD(NRD), .SWAP_BYTES(1)) u_swp (
    .clk_i(clk), .nreset_i(nreset), .spi_cs_i(cs), .spi_rxtx_done_i(done),
    .spi_rx_word_i(rx_sw), .spi_tx_word_o(tx_sw), .wr_data_o(wr_sw),
    .wr_stb_o(stb_sw), .rd_data_i(rd_data), .status_o(status_sw));

  // Model state
  logic [DW-1:0] m_wr [NWR];
  logic [W-1:0]  m_tx;
  logic          m_ea, m_eb, m_seen;
  int            m_cnt;
  logic [NWR-1:0] m_stb;
  int            pend_cyc = -1;
  logic [W-1:0]  pend_word;
  int            pabort = -1;
  int            npass = 0, ntot = 0;
  int            stb_cycles = 0, last_stb_cyc = 0, last_raise = 0;
  logic [NWR-1:0] last_stb_val = '0;

  function automatic logic [15:0] swb(input logic [15:0] x);
    return {x[7:0], x[15:8]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_clear();
    for (int k = 0; k < NWR; k++) m_wr[k] = '0;
    m_tx = '0; m_ea = 1'b0; m_eb = 1'b0; m_seen = 1'b0; m_cnt = 0;
  endtask

  // Register-map rules applied to one command word.
  task automatic model_apply(input logic [W-1:0] w);
    logic op;
    int a;
    logic [DW-1:0] d;
    bit clr;
    op = w[W-1]; a = int'(w[W-2 -: AW]); d = w[DW-1:0]; clr = 0;
    if (a == (1 << AW) - 1) begin
      if (!op) m_tx = {1'b0, AW'(a), CW'(m_cnt), m_eb, m_ea};
      else if (d[0]) begin m_ea = 0; m_eb = 0; m_cnt = 0; clr = 1; end
    end else if (op) begin
      if (a < NWR) begin m_wr[a] = d; m_stb[a] = 1'b1; end
      else m_ea = 1'b1;
    end else begin
      if (a < NRD) m_tx = {1'b0, AW'(a), rd_data[a*DW +: DW]};
      else begin m_tx = '0; m_ea = 1'b1; end
    end
    if (!clr) m_cnt = (m_cnt + 1) % (1 << CW);
    m_seen = 1'b1;
  endtask

  task automatic compare_cycle();
    logic [NWR*DW-1:0] ew;
    if (!nreset) model_clear();
    m_stb = '0;
    if (pend_cyc == cyc) model_apply(pend_word);
    if (pabort == cyc && !m_seen) m_eb = 1'b1;
    for (int k = 0; k < NWR; k++) ew[k*DW +: DW] = m_wr[k];
    chk("wr_data", 64'(wr), 64'(ew));
    chk("wr_data_swap", 64'(wr_sw), 64'(ew));
    chk("wr_stb", 64'(stb), 64'(m_stb));
    chk("wr_stb_swap", 64'(stb_sw), 64'(m_stb));
    chk("tx_word", 64'(tx), 64'(m_tx));
    chk("tx_word_swap", 64'(tx_sw), 64'(swb(m_tx)));
    chk("status", 64'(status), 64'({m_eb, m_ea}));
    chk("status_swap", 64'(status_sw), 64'({m_eb, m_ea}));
    if (stb != '0) begin stb_cycles++; last_stb_cyc = cyc; last_stb_val = stb; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    nreset = 1'b0;
    pend_cyc = -1; pabort = -1;
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int h, input int l);
    @(posedge clk); #1;
    rx = w; done = 1'b1;
    last_raise = cyc; pend_cyc = cyc + 4; pend_word = w;
    repeat (h) @(posedge clk);
    #1 done = 1'b0;
    repeat (l) @(posedge clk);
  endtask

  task automatic cs_on();
    @(posedge clk); #1 cs = 1'b0; m_seen = 1'b0;
  endtask

  task automatic cs_off();
    @(posedge clk); #1 cs = 1'b1; pabort = cyc + 3;
  endtask

  initial begin
    int snap;
    logic [W-1:0] w;
    model_clear();
    m_stb = '0;
    fork
      forever begin @(negedge clk); compare_cycle(); end
    join_none

    do_reset();
    repeat (5) @(posedge clk);
    rd_data = {$urandom, $urandom};
    rd_data[2*DW +: DW] = 11'h123;

    send_word(16'hA003, 6, 6);
    chk("lit_err_addr", 64'(status), 64'(2'b01));
    chk("lit_no_stb", 64'(stb_cycles), 64'(0));
    send_word(16'h8805, 6, 6);
    chk("lit_stb_delay", 64'(last_stb_cyc - last_raise), 64'(4));
    chk("lit_stb_val", 64'(last_stb_val), 64'(4'b0010));
    chk("lit_stb_once", 64'(stb_cycles), 64'(1));
    chk("lit_wr1", 64'(wr[DW +: DW]), 64'(5));
    chk("lit_wr1_swap", 64'(wr_sw[DW +: DW]), 64'(5));
    send_word(16'h1000, 7, 5);
    chk("lit_rd2", 64'(tx), 64'(16'h1123));
    chk("lit_rd2_swap", 64'(tx_sw), 64'(16'h2311));
    send_word(16'h7800, 6, 6);
    chk("lit_stat_rd", 64'(tx), 64'(16'h780D));
    send_word(16'h8001, 6, 6);
    send_word(16'h9002, 6, 6);
    send_word(16'h9803, 6, 6);
    chk("lit_tx_hold", 64'(tx), 64'(16'h780D));
    send_word(16'hF801, 6, 6);
    chk("lit_stat_clr", 64'(status), 64'(2'b00));
    send_word(16'h7800, 6, 6);
    chk("lit_cnt_clr", 64'(tx), 64'(16'h7800));

    cs_on();
    repeat (10) @(posedge clk);
    cs_off();
    repeat (6) @(posedge clk);
    chk("lit_abort", 64'(status), 64'(2'b10));
    send_word(16'hF801, 6, 6);
    chk("lit_abort_clr", 64'(status), 64'(2'b00));
    cs_on();
    repeat (4) @(posedge clk);
    send_word(16'h8801, 6, 6);
    cs_off();
    repeat (6) @(posedge clk);
    chk("lit_no_abort", 64'(status), 64'(2'b00));

    // Done high across reset: the interrupted word and the held level are ignored.
    @(posedge clk); #1;
    rx = 16'h8805; done = 1'b1;
    snap = stb_cycles;
    do_reset();
    repeat (10) @(posedge clk);
    chk("lit_done_held", 64'(stb_cycles), 64'(snap));
    #1 done = 1'b0;
    repeat (6) @(posedge clk);
    send_word(16'h8805, 6, 6);
    chk("lit_rearm", 64'(stb_cycles), 64'(snap + 1));

    send_word(16'hF801, 6, 6);
    for (int i = 0; i < (1 << CW); i++) begin
      rd_data = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) w = 16'h7800;
      else w = {1'($urandom), 4'($urandom_range(0, 14)), 11'($urandom)};
      send_word(w, $urandom_range(6, 9), $urandom_range(5, 7));
    end
    send_word(16'h7800, 6, 6);
    chk("lit_cnt_wrap", 64'(tx[DW-1:2]), 64'(0));

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
